uart_rx_8n1: RTL and testbench

- Serial receiver for 8 data bits, no parity, 1 stop bit. It is the receive counterpart of the 8N1 transmitter that sends over the FTDI USB bridge.
- Samples the asynchronous ftdi_rx line at 16x the baud rate, derived from the 12 MHz hardware clock.
- Validates the start and stop bits and presents each received byte through a valid/ready holding register.
- Sits between the FTDI RX pin and user logic, e.g. a command decoder or LED control.

---
 rtl/uart_rx_8n1_if.sv | 28 ++
 rtl/uart_rx_8n1.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Receive-side handshake bundle for uart_rx_8n1.
// master = the receiver (produces bytes and status), slave = the consumer.
interface uart_rx_8n1_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversampling with a 3-sample majority vote per bit,
// start-glitch rejection, stop-bit validation and a valid/ready holding register.
module uart_rx_8n1 #(
  parameter int CLK_HZ  = 12000000,
  parameter int BAUD    = 9600,
  parameter int OVS_DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic          hwclk,
  input  logic          rst_n,
  input  logic          ftdi_rx,
  uart_rx_8n1_if.master rx_bus
);

  localparam int                 CNT_W   = (OVS_DIV > 2) ? $clog2(OVS_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(OVS_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two of three samples agree: tolerates a single noisy sample per bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_s_d_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       s_q;
  logic [2:0]       b_q;
  logic             smp7_q;
  logic             smp8_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_busy_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic tick_s;
  logic fall_s;
  logic vote_s;
  logic accept_s;

  // The tick counter is held at 0 in IDLE, so no tick can fire there.
  assign tick_s   = (cnt_q == CNT_MAX);
  assign fall_s   = rx_s_d_q & ~rx_s_q;
  // The s=9 sample is the live synchronized line on the deciding tick.
  assign vote_s   = maj3(smp7_q, smp8_q, rx_s_q);
  assign accept_s = rx_valid_q & rx_bus.rx_ready;

  assign rx_bus.rx_data   = rx_data_q;
  assign rx_bus.rx_valid  = rx_valid_q;
  assign rx_bus.rx_busy   = rx_busy_q;
  assign rx_bus.frame_err = frame_err_q;
  assign rx_bus.overrun   = overrun_q;

  // Synchronize the asynchronous line and keep one extra stage for edge detection.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
    end else begin
      rx_meta_q <= ftdi_rx;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
    end
  end

  // Frame FSM with bit timing, shift register and registered handshake/status outputs.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= 4'd0;
      b_q         <= 3'd0;
      smp7_q      <= 1'b1;
      smp8_q      <= 1'b1;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (accept_s) begin
        rx_valid_q <= 1'b0;
      end

      // Bit timing: locked to the start edge, advancing one sample index per tick.
      if (state_q == IDLE) begin
        cnt_q <= '0;
        s_q   <= 4'd0;
      end else if (tick_s) begin
        cnt_q <= '0;
        s_q   <= s_q + 4'd1;
        if (s_q == 4'd7) begin
          smp7_q <= rx_s_q;
        end
        if (s_q == 4'd8) begin
          smp8_q <= rx_s_q;
        end
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end

      case (state_q)
        IDLE: begin
          b_q <= 3'd0;
          // Only a fresh high-to-low edge starts a frame; a held-low line does not.
          if (fall_s) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (tick_s && (s_q == 4'd9) && vote_s) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end else if (tick_s && (s_q == 4'd15)) begin
            state_q <= DATA;
            b_q     <= 3'd0;
          end
        end
        DATA: begin
          if (tick_s && (s_q == 4'd9)) begin
            shift_q <= {vote_s, shift_q[7:1]};
          end
          if (tick_s && (s_q == 4'd15)) begin
            b_q <= b_q + 3'd1;
            if (b_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          // Decide mid stop bit and leave at once to leave slack for the next start edge.
          if (tick_s && (s_q == 4'd9)) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
            if (vote_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !rx_bus.rx_ready) begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: a serial driver pushes the bytes it expects
// to be delivered, an independent monitor pops and compares on each delivery.
module tb_uart_rx_8n1;
  localparam int BAUD    = 9600;
  localparam int OVS     = 16;
  localparam int CLK_HZ  = BAUD * 16 * OVS;
  localparam int BIT     = 16 * OVS;
  localparam int FRAME   = 10 * BIT;
  localparam int SKEW    = BIT / 50;
  localparam int GLITCH  = (300 * BIT) / 1248;
  localparam int LATENCY = 9 * 16 * OVS + 10 * OVS + 3;

  logic hwclk   = 1'b0;
  logic rst_n   = 1'b0;
  logic ftdi_rx = 1'b1;

  uart_rx_8n1_if bus ();

  uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .hwclk  (hwclk),
    .rst_n  (rst_n),
    .ftdi_rx(ftdi_rx),
    .rx_bus (bus)
  );

  always #5 hwclk = ~hwclk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         n_fe = 0;
  int         n_ov = 0;
  int         n_deliv = 0;
  int         n_vcyc = 0;
  bit         busy_seen = 1'b0;
  longint     cyc = 0;
  longint     last_start_cyc = 0;
  longint     last_load_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Free-running cycle count for latency measurement.
  always @(posedge hwclk) cyc <= cyc + 1;

  // Monitor: classify each cycle's outputs and compare deliveries against the queue.
  initial begin : monitor
    logic pv;
    logic pr;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge hwclk);
      if (!rst_n) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (bus.rx_valid) n_vcyc++;
        // A byte is newly presented if valid rose, the previous one was taken,
        // or it overwrote an unconsumed one.
        if (bus.rx_valid && (!pv || pr || bus.overrun)) begin
          n_deliv++;
          last_load_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no delivery", bus.rx_data);
          end else begin
            check("rx_data", int'(bus.rx_data), int'(exp_q.pop_front()));
          end
        end
        if (pv && !pr) check("valid_hold", int'(bus.rx_valid), 1);
        if (bus.frame_err) n_fe++;
        if (bus.overrun) n_ov++;
        if (bus.rx_busy) busy_seen = 1'b1;
        pv = bus.rx_valid;
        pr = bus.rx_ready;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  // Drive one 8N1 frame LSB first; bytes with a good stop bit are expected.
  task automatic send(input logic [7:0] b, input int bitlen, input bit stop_ok);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    if (stop_ok) exp_q.push_back(b);
    last_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      ftdi_rx = frame[i];
      tick(bitlen);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"},   int'(bus.rx_data),   0);
    check({tag, "_rx_valid"},  int'(bus.rx_valid),  0);
    check({tag, "_rx_busy"},   int'(bus.rx_busy),   0);
    check({tag, "_frame_err"}, int'(bus.frame_err), 0);
    check({tag, "_overrun"},   int'(bus.overrun),   0);
  endtask

  // Watchdog: the run must always end on its own.
  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int v0, d0, fe0, ov0;
    logic [7:0] rb;
    int bl;
    bus.rx_ready = 1'b1;
    ftdi_rx      = 1'b1;
    rst_n        = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(5);

    // Back-to-back frames, consumer always ready.
    v0 = n_vcyc;
    send(8'h55, BIT, 1'b1);
    check("latency", int'(last_load_cyc - last_start_cyc), LATENCY);
    send(8'hA3, BIT, 1'b1);
    drain("b2b_drain");
    tick(2);
    check("b2b_valid_cycles", n_vcyc - v0, 2);
    check("b2b_frame_err", n_fe, 0);
    check("b2b_overrun", n_ov, 0);
    tick(BIT);

    // Overrun: consumer not ready across two frames.
    ov0 = n_ov;
    bus.rx_ready = 1'b0;
    send(8'h30, BIT, 1'b1);
    send(8'h31, BIT, 1'b1);
    drain("ovr_drain");
    check("ovr_data", int'(bus.rx_data), 8'h31);
    check("ovr_valid", int'(bus.rx_valid), 1);
    check("ovr_pulses", n_ov - ov0, 1);
    bus.rx_ready = 1'b1;
    tick(1);
    check("ovr_valid_drop", int'(bus.rx_valid), 0);
    tick(BIT);

    // Framing error followed by a line held low (break).
    fe0 = n_fe;
    send(8'h7E, BIT, 1'b0);
    tick(3 * FRAME);
    check("ferr_pulses", n_fe - fe0, 1);
    check("ferr_valid", int'(bus.rx_valid), 0);
    check("ferr_busy", int'(bus.rx_busy), 0);
    ftdi_rx = 1'b1;
    tick(2 * BIT);
    send(8'h41, BIT, 1'b1);
    drain("ferr_recover");
    check("ferr_pulses_after", n_fe - fe0, 1);
    tick(BIT);

    // Short low glitch on an idle line is rejected as a false start.
    busy_seen = 1'b0;
    d0  = n_deliv;
    fe0 = n_fe;
    ftdi_rx = 1'b0;
    tick(GLITCH);
    ftdi_rx = 1'b1;
    tick(2 * BIT);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_end", int'(bus.rx_busy), 0);
    check("glitch_no_byte", n_deliv - d0, 0);
    check("glitch_no_ferr", n_fe - fe0, 0);

    // Baud rate skew of about +-2%.
    send(8'hC3, BIT - SKEW, 1'b1);
    tick(BIT);
    send(8'hC3, BIT + SKEW, 1'b1);
    drain("skew_drain");
    tick(BIT);

    // Reset in the middle of data bit 4 of 0xFF.
    d0 = n_deliv;
    ftdi_rx = 1'b0;
    tick(BIT);
    ftdi_rx = 1'b1;
    tick(4 * BIT + BIT / 2);
    rst_n = 1'b0;
    tick(2);
    check_all_zero("midreset");
    tick(BIT);
    rst_n = 1'b1;
    tick(3 * BIT);
    check("midreset_no_byte", n_deliv - d0, 0);
    send(8'h12, BIT, 1'b1);
    drain("midreset_recover");
    check("midreset_one_byte", n_deliv - d0, 1);
    tick(BIT);

    // Random bytes, rates and idle gaps.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      bl = int'($urandom_range(BIT - SKEW, BIT + SKEW));
      send(rb, bl, 1'b1);
      tick(int'($urandom_range(0, BIT)));
    end
    drain("random_drain");
    tick(BIT);

    check("total_frame_err", n_fe, 1);
    check("total_overrun", n_ov, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
